dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// request-to-response latency.
//
// Byte-addressed accesses (word/half/byte, signed and unsigned) go to a
// DEPTH_WORDS x 32 array. Stores commit on the acceptance edge. Loads read
// the addressed word on that same edge. The response appears LATENCY cycles
// later and is held until it is handshaked.
//
// Ports
//   clk, reset                          clock, synchronous active-high reset
//   req_valid/req_ready                 request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata         store flag, byte address, store data
//   req_type                            000 w, 001 h, 010 hu, 011 b, 100 bu
//   resp_valid/resp_ready               response handshake
//   resp_rdata, resp_err                load result / misaligned-or-illegal flag
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_type,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic        err_q;

  logic          accept;
  logic [AW-1:0] idx;
  logic          err;
  logic [3:0]    wmask;
  logic [31:0]   wword;
  logic [31:0]   cur, cur_sh, ld;
  logic [15:0]   half;
  logic [7:0]    byte_v;

  // Address bits above the array size wrap silently.
  logic unused_addr;
  assign unused_addr = &{1'b0, req_addr[31:AW+2]};

  // Reset wins over a request presented in the same cycle.
  assign accept = req_valid & req_ready & ~reset;
  assign idx    = req_addr[AW+1:2];

  // Alignment / type legality plus store lane mask, all from the live request.
  always_comb begin
    err   = 1'b0;
    wmask = 4'b0000;
    wword = req_wdata;
    case (req_type)
      3'b000: begin
        err   = |req_addr[1:0];
        wmask = 4'b1111;
      end
      3'b001, 3'b010: begin
        err   = req_addr[0];
        wmask = req_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{req_wdata[15:0]}};
      end
      3'b011, 3'b100: begin
        wmask = 4'b0001 << req_addr[1:0];
        wword = {4{req_wdata[7:0]}};
      end
      default: err = 1'b1;
    endcase
  end

  // Load extraction from the word as it stands before this edge's write.
  assign cur    = mem[idx];
  assign cur_sh = cur >> {req_addr[1:0], 3'b000};
  assign byte_v = cur_sh[7:0];
  assign half   = req_addr[1] ? cur[31:16] : cur[15:0];

  always_comb begin
    ld = 32'h0;
    if (!req_we && !err) begin
      case (req_type)
        3'b000:  ld = cur;
        3'b001:  ld = {{16{half[15]}}, half};
        3'b010:  ld = {16'h0, half};
        3'b011:  ld = {{24{byte_v[7]}}, byte_v};
        3'b100:  ld = {24'h0, byte_v};
        default: ld = 32'h0;
      endcase
    end
  end

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        rdata_q <= ld;
        err_q   <= err;
      end
    end
  end

  // WAIT leaves when the counter would hit zero, so resp_valid is first
  // sampled by the initiator on the LATENCY-th edge after acceptance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        cnt_nxt   = 4'(LATENCY - 1);
        state_nxt = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid & err_q;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_type;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  localparam logic [2:0] T_W = 3'b000, T_H = 3'b001, T_HU = 3'b010,
                         T_B = 3'b011, T_BU = 3'b100;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // One full transaction: waits for ready, checks latency and idle-zero
  // outputs, pops the scoreboard on response, optionally stalls resp_ready.
  task automatic send(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] typ,
                      input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int   n;
    exp_t e;
    q.push_back('{exp_rd, exp_err});
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_ready timeout: got %b want 1", name, req_ready);
      void'(q.pop_back());
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_type = typ;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (resp_valid !== 1'b1 && n < 40) begin
      n_chk++;
      if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle outputs: rdata %h err %b want 0 0", name, resp_rdata, resp_err);
      end
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n != LATENCY) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, n, LATENCY);
    end
    if (resp_valid !== 1'b1) begin
      void'(q.pop_front());
      return;
    end
    e = q.pop_front();
    n_chk++;
    if (resp_rdata !== e.rdata || resp_err !== e.err) begin
      n_fail++;
      $display("FAIL %s data: got %h err %b want %h err %b", name, resp_rdata, resp_err, e.rdata, e.err);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      n_chk++;
      if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall%0d: valid %b rdata %h err %b ready %b want 1 %h %b 0",
                 name, i, resp_valid, resp_rdata, resp_err, req_ready, e.rdata, e.err);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    n_chk++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s post-handshake: valid %b ready %b want 0 1", name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready %b valid %b rdata %h err %b want 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
  endtask

  task automatic test_word();
    send("sw_10", 1'b1, 32'h10, 32'h12345678, T_W, 32'h0, 1'b0, 0);
    send("lw_10", 1'b0, 32'h10, 32'h0, T_W, 32'h12345678, 1'b0, 0);
  endtask

  task automatic test_byte();
    send("sb_11",  1'b1, 32'h11, 32'h00000080, T_B,  32'h0, 1'b0, 0);
    send("lb_11",  1'b0, 32'h11, 32'h0, T_B,  32'hFFFFFF80, 1'b0, 0);
    send("lbu_11", 1'b0, 32'h11, 32'h0, T_BU, 32'h00000080, 1'b0, 0);
    send("lw_10b", 1'b0, 32'h10, 32'h0, T_W,  32'h12348078, 1'b0, 0);
  endtask

  task automatic test_half();
    send("sh_12",   1'b1, 32'h12, 32'h0000BEEF, T_H,  32'h0, 1'b0, 0);
    send("lh_12",   1'b0, 32'h12, 32'h0, T_H,  32'hFFFFBEEF, 1'b0, 0);
    send("lhu_12",  1'b0, 32'h12, 32'h0, T_HU, 32'h0000BEEF, 1'b0, 0);
    send("sh_13",   1'b1, 32'h13, 32'h00001234, T_H,  32'h0, 1'b1, 0);
    send("lw_10h",  1'b0, 32'h10, 32'h0, T_W,  32'hBEEF8078, 1'b0, 0);
  endtask

  task automatic test_errors();
    send("lw_mis",  1'b0, 32'h11, 32'h0, T_W,    32'h0, 1'b1, 0);
    send("lh_mis",  1'b0, 32'h11, 32'h0, T_H,    32'h0, 1'b1, 0);
    send("sw_mis",  1'b1, 32'h12, 32'hFFFFFFFF, T_W, 32'h0, 1'b1, 0);
    send("typ_101", 1'b0, 32'h10, 32'h0, 3'b101, 32'h0, 1'b1, 0);
    send("lw_10e",  1'b0, 32'h10, 32'h0, T_W,    32'hBEEF8078, 1'b0, 0);
  endtask

  task automatic test_stall();
    send("lw_stall", 1'b0, 32'h10, 32'h0, T_W, 32'hBEEF8078, 1'b0, 5);
  endtask

  task automatic test_wrap();
    send("sw_200", 1'b1, 32'h200, 32'hA5A5A5A5, T_W, 32'h0, 1'b0, 0);
    send("lw_000", 1'b0, 32'h000, 32'h0, T_W, 32'hA5A5A5A5, 1'b0, 0);
  endtask

  task automatic test_reset_abort();
    send("sw_80", 1'b1, 32'h80, 32'h11111111, T_W, 32'h0, 1'b0, 0);
    // Reset with a simultaneous store: the store must be dropped.
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 32'h80; req_wdata = 32'h22222222; req_type = T_W;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    send("lw_80", 1'b0, 32'h80, 32'h0, T_W, 32'h11111111, 1'b0, 0);
    // Store accepted, then reset in WAIT: no response, store persists.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
    req_wdata = 32'hCAFEF00D; req_type = T_W;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: valid %b ready %b want 0 1", resp_valid, req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_resp cycle %0d: valid %b want 0", i, resp_valid);
      end
    end
    send("lw_40", 1'b0, 32'h40, 32'h0, T_W, 32'hCAFEF00D, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_type = 3'b000; resp_ready = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_stall();
    test_wrap();
    test_reset_abort();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
